univshift_ctrl: RTL and testbench

- Command sequencer for the 4-bit universal shift register.
- Accepts one command per transaction on a valid/ready port: optional parallel load, then N cycles of a chosen shift/rotate mode.
- Drives the shifter's select and load inputs, then captures the shifter's final Q and returns it on a valid/ready response port.
- Sits between a bus-side requester and the shifter; the shifter's own datapath is unchanged.

---
 rtl/univshift_pkg.sv | 30 +++
 rtl/univshift_cnt.sv | 34 +++
 rtl/univshift_ctrl.sv | 156 +++++++++++++++
 tb/tb_univshift_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/univshift_pkg.sv
// univshift_pkg: shared definitions for the universal shift register
// command sequencer.
//   - US_* select encodings driven onto the shifter's S input
//   - state_t: sequencer FSM states
//   - is_legal_mode(): whether a command mode can be driven onto S
package univshift_pkg;

  localparam logic [2:0] US_HOLD = 3'd0;
  localparam logic [2:0] US_SHR  = 3'd1;  // zero fill
  localparam logic [2:0] US_SHL  = 3'd2;
  localparam logic [2:0] US_ROR  = 3'd3;
  localparam logic [2:0] US_ROL  = 3'd4;
  localparam logic [2:0] US_ASR  = 3'd5;
  localparam logic [2:0] US_RSVD = 3'd6;
  localparam logic [2:0] US_LOAD = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_SHIFT   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_RESP    = 3'd4
  } state_t;

  // US_LOAD is a valid select but not a valid shift-phase mode.
  function automatic logic is_legal_mode(input logic [2:0] mode);
    return !((mode == US_LOAD) || (mode == US_RSVD));
  endfunction

endpackage

// File: rtl/univshift_cnt.sv
// univshift_cnt: loadable down-counter with zero flag.
// Ports:
//   clk      - rising-edge clock
//   rstn     - synchronous reset, active-low (clears count)
//   load     - load load_val (has priority over dec)
//   load_val - value to load
//   dec      - decrement; saturates at zero, never wraps
//   cnt      - current remaining count
//   zero     - cnt == 0
module univshift_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/univshift_ctrl.sv
// univshift_ctrl: command sequencer for the universal shift register.
// Takes one command (optional parallel load, then N shift cycles in a
// chosen mode), drives the shifter's S/L inputs, captures its Q and
// returns it on a valid/ready response port.
// Ports:
//   Clock, Resetn                - clock, synchronous active-low reset
//   cmd_valid/cmd_ready          - command handshake (ready only in IDLE)
//   cmd_load/mode/count/data     - command fields
//   cmd_abort                    - only when UNIVSHIFT_ABORT_EN is defined
//   S, L                         - registered shifter select / load value
//   Q                            - shifter output (passed through untouched)
//   rsp_valid/rsp_ready          - response handshake
//   rsp_data, rsp_err            - captured Q, illegal-mode/abort flag
// Build option: define UNIVSHIFT_ABORT_EN to add the cmd_abort input.
//
// state   | meaning
// IDLE    | waiting for a command, S=HOLD
// LOAD    | S=LOAD, shifter loads L on the next edge
// SHIFT   | S=mode for exactly count edges
// CAPTURE | sample Q into rsp_data
// RESP    | response held until rsp_ready
module univshift_ctrl
  import univshift_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 4
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_load,
  input  logic [2:0]        cmd_mode,
  input  logic [CNT_W-1:0]  cmd_count,
  input  logic [DATA_W-1:0] cmd_data,
`ifdef UNIVSHIFT_ABORT_EN
  input  logic              cmd_abort,
`endif
  output logic [2:0]        S,
  output logic [DATA_W-1:0] L,
  input  logic [DATA_W-1:0] Q,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err
);

  state_t            state;
  logic [2:0]        mode_q;
  logic              err_q;
  logic              abort;
  logic              cmd_legal;
  logic [2:0]        cmd_mode_eff;
  logic              cnt_load;
  logic              cnt_dec;
  logic [CNT_W-1:0]  cnt;
  logic              cnt_zero;
  logic              cnt_last;

`ifdef UNIVSHIFT_ABORT_EN
  assign abort = cmd_abort;
`else
  assign abort = 1'b0;
`endif

  // Illegal modes are replaced by HOLD so cycle timing is unchanged.
  assign cmd_legal    = is_legal_mode(cmd_mode);
  assign cmd_mode_eff = cmd_legal ? cmd_mode : US_HOLD;

  assign cmd_ready = (state == ST_IDLE);
  assign cnt_load  = (state == ST_IDLE) && cmd_valid;
  assign cnt_dec   = (state == ST_SHIFT);
  assign cnt_last  = (cnt == CNT_W'(1));

  univshift_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk      (Clock),
    .rstn     (Resetn),
    .load     (cnt_load),
    .load_val (cmd_count),
    .dec      (cnt_dec),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state     <= ST_IDLE;
      S         <= US_HOLD;
      L         <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      mode_q    <= US_HOLD;
      err_q     <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            mode_q <= cmd_mode_eff;
            err_q  <= !cmd_legal;
            if (cmd_load) begin
              state <= ST_LOAD;
              S     <= US_LOAD;
              L     <= cmd_data;
            end else if (cmd_count != '0) begin
              state <= ST_SHIFT;
              S     <= cmd_mode_eff;
            end else begin
              state <= ST_CAPTURE;
            end
          end
        end
        ST_LOAD: begin
          // The shifter loads on this edge regardless of abort.
          if (abort) begin
            S     <= US_HOLD;
            state <= ST_CAPTURE;
            err_q <= 1'b1;
          end else if (!cnt_zero) begin
            S     <= mode_q;
            state <= ST_SHIFT;
          end else begin
            S     <= US_HOLD;
            state <= ST_CAPTURE;
          end
        end
        ST_SHIFT: begin
          // S is already applied, so the shift on this edge happens even
          // when an abort arrives with it.
          if (abort || cnt_last) begin
            S     <= US_HOLD;
            state <= ST_CAPTURE;
            if (abort) err_q <= 1'b1;
          end
        end
        ST_CAPTURE: begin
          rsp_data  <= Q;
          rsp_err   <= err_q;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          S     <= US_HOLD;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_univshift_ctrl.sv
// tb_univshift_ctrl: directed bench for univshift_ctrl with a behavioural
// 4-bit universal shift register wired to S/L/Q.
// Build option: UNIVSHIFT_ABORT_EN enables the abort scenario.
module tb_univshift_ctrl;
  import univshift_pkg::*;

  logic       Clock = 1'b0;
  logic       Resetn = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_load = 1'b0;
  logic [2:0] cmd_mode = 3'd0;
  logic [3:0] cmd_count = 4'd0;
  logic [3:0] cmd_data = 4'd0;
`ifdef UNIVSHIFT_ABORT_EN
  logic       cmd_abort = 1'b0;
`endif
  logic [2:0] S;
  logic [3:0] L;
  logic [3:0] Q = 4'd0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [3:0] rsp_data;
  logic       rsp_err;

  int checks = 0;
  int failures = 0;
  int edges;
  logic [2:0] s_log [0:31];

  univshift_ctrl #(.DATA_W(4), .CNT_W(4)) dut (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_load  (cmd_load),
    .cmd_mode  (cmd_mode),
    .cmd_count (cmd_count),
    .cmd_data  (cmd_data),
`ifdef UNIVSHIFT_ABORT_EN
    .cmd_abort (cmd_abort),
`endif
    .S         (S),
    .L         (L),
    .Q         (Q),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err)
  );

  always #5 Clock = ~Clock;

  // Behavioural shifter; not affected by controller reset.
  always @(posedge Clock) begin
    case (S)
      US_SHR:  Q <= {1'b0, Q[3:1]};
      US_SHL:  Q <= {Q[2:0], 1'b0};
      US_ROR:  Q <= {Q[0], Q[3:1]};
      US_ROL:  Q <= {Q[2:0], Q[3]};
      US_ASR:  Q <= {Q[3], Q[3:1]};
      US_LOAD: Q <= L;
      default: Q <= Q;
    endcase
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issue one command, then wait (bounded) for rsp_valid. edges counts the
  // accept edge as 1; s_log[i] is S after edge i+1.
  task automatic run_cmd(input logic ld, input logic [2:0] md,
                         input logic [3:0] cnt, input logic [3:0] dat);
    @(negedge Clock);
    cmd_valid = 1'b1; cmd_load = ld; cmd_mode = md;
    cmd_count = cnt;  cmd_data = dat;
    @(posedge Clock);
    edges = 1;
    @(negedge Clock);
    cmd_valid = 1'b0;
    s_log[0] = S;
    while (!rsp_valid && edges < 40) begin
      @(posedge Clock);
      edges++;
      @(negedge Clock);
      if (edges <= 32) s_log[edges-1] = S;
    end
  endtask

  task automatic finish_rsp();
    @(negedge Clock);
    rsp_ready = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    Resetn = 1'b0;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready got=%0b exp=1", cmd_ready); end
    checks++; if (S !== US_HOLD) begin failures++; $display("FAIL reset_S got=%0d exp=%0d", S, US_HOLD); end
    checks++; if (L !== 4'd0) begin failures++; $display("FAIL reset_L got=%b exp=0000", L); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%0b exp=0", rsp_valid); end
    checks++; if (rsp_data !== 4'd0) begin failures++; $display("FAIL reset_rsp_data got=%b exp=0000", rsp_data); end
    checks++; if (rsp_err !== 1'b0) begin failures++; $display("FAIL reset_rsp_err got=%0b exp=0", rsp_err); end
    Resetn = 1'b1;
  endtask

  task automatic test_load_shl();
    logic [2:0] exp_s [0:3];
    exp_s = '{US_LOAD, US_SHL, US_HOLD, US_HOLD};
    run_cmd(1'b1, US_SHL, 4'd1, 4'b1011);
    checks++; if (edges !== 4) begin failures++; $display("FAIL shl_latency got=%0d exp=4", edges); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (s_log[i] !== exp_s[i]) begin failures++; $display("FAIL shl_S[%0d] got=%0d exp=%0d", i, s_log[i], exp_s[i]); end
    end
    checks++; if (rsp_data !== 4'b0110) begin failures++; $display("FAIL shl_data got=%b exp=0110", rsp_data); end
    checks++; if (rsp_err !== 1'b0) begin failures++; $display("FAIL shl_err got=%0b exp=0", rsp_err); end
    checks++; if (L !== 4'b1011) begin failures++; $display("FAIL shl_L got=%b exp=1011", L); end
    finish_rsp();
    checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin failures++; $display("FAIL shl_done valid=%0b ready=%0b exp 0/1", rsp_valid, cmd_ready); end
  endtask

  task automatic test_load_ror();
    run_cmd(1'b1, US_ROR, 4'd2, 4'b1011);
    checks++; if (edges !== 5) begin failures++; $display("FAIL ror_latency got=%0d exp=5", edges); end
    checks++; if (rsp_data !== 4'b1110) begin failures++; $display("FAIL ror_data got=%b exp=1110", rsp_data); end
    checks++; if (rsp_err !== 1'b0) begin failures++; $display("FAIL ror_err got=%0b exp=0", rsp_err); end
    finish_rsp();
  endtask

  task automatic test_noload_count0();
    run_cmd(1'b0, US_SHR, 4'd0, 4'b0000);
    checks++; if (edges !== 2) begin failures++; $display("FAIL cnt0_latency got=%0d exp=2", edges); end
    for (int i = 0; i < 2; i++) begin
      checks++; if (s_log[i] !== US_HOLD) begin failures++; $display("FAIL cnt0_S[%0d] got=%0d exp=%0d", i, s_log[i], US_HOLD); end
    end
    checks++; if (rsp_data !== 4'b1110) begin failures++; $display("FAIL cnt0_data got=%b exp=1110", rsp_data); end
    checks++; if (L !== 4'b1011) begin failures++; $display("FAIL cnt0_L_held got=%b exp=1011", L); end
    finish_rsp();
  endtask

  task automatic test_illegal_mode();
    logic [2:0] exp_s [0:5];
    exp_s = '{US_LOAD, US_HOLD, US_HOLD, US_HOLD, US_HOLD, US_HOLD};
    run_cmd(1'b1, US_LOAD, 4'd3, 4'b1000);
    checks++; if (edges !== 6) begin failures++; $display("FAIL illegal_latency got=%0d exp=6", edges); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (s_log[i] !== exp_s[i]) begin failures++; $display("FAIL illegal_S[%0d] got=%0d exp=%0d", i, s_log[i], exp_s[i]); end
    end
    checks++; if (rsp_data !== 4'b1000) begin failures++; $display("FAIL illegal_data got=%b exp=1000", rsp_data); end
    checks++; if (rsp_err !== 1'b1) begin failures++; $display("FAIL illegal_err got=%0b exp=1", rsp_err); end
    finish_rsp();
    run_cmd(1'b0, US_RSVD, 4'd2, 4'b0000);
    checks++; if (edges !== 4) begin failures++; $display("FAIL rsvd_latency got=%0d exp=4", edges); end
    checks++; if (rsp_data !== 4'b1000 || rsp_err !== 1'b1) begin failures++; $display("FAIL rsvd_rsp data=%b err=%0b exp 1000/1", rsp_data, rsp_err); end
    finish_rsp();
  endtask

  task automatic test_hold_mode();
    run_cmd(1'b0, US_HOLD, 4'd2, 4'b0000);
    checks++; if (edges !== 4) begin failures++; $display("FAIL hold_latency got=%0d exp=4", edges); end
    checks++; if (rsp_data !== 4'b1000 || rsp_err !== 1'b0) begin failures++; $display("FAIL hold_rsp data=%b err=%0b exp 1000/0", rsp_data, rsp_err); end
    finish_rsp();
  endtask

  task automatic test_modes();
    run_cmd(1'b1, US_SHR, 4'd1, 4'b1011);
    checks++; if (rsp_data !== 4'b0101) begin failures++; $display("FAIL shr_data got=%b exp=0101", rsp_data); end
    finish_rsp();
    run_cmd(1'b1, US_ASR, 4'd2, 4'b1000);
    checks++; if (rsp_data !== 4'b1110) begin failures++; $display("FAIL asr_data got=%b exp=1110", rsp_data); end
    finish_rsp();
    run_cmd(1'b1, US_ROL, 4'd15, 4'b0001);
    checks++; if (edges !== 18) begin failures++; $display("FAIL max_count_latency got=%0d exp=18", edges); end
    checks++; if (rsp_data !== 4'b1000) begin failures++; $display("FAIL max_count_data got=%b exp=1000", rsp_data); end
    checks++; if (rsp_err !== 1'b0) begin failures++; $display("FAIL max_count_err got=%0b exp=0", rsp_err); end
    finish_rsp();
    run_cmd(1'b1, US_SHL, 4'd0, 4'b0101);
    checks++; if (edges !== 3) begin failures++; $display("FAIL load_cnt0_latency got=%0d exp=3", edges); end
    checks++; if (rsp_data !== 4'b0101) begin failures++; $display("FAIL load_cnt0_data got=%b exp=0101", rsp_data); end
    finish_rsp();
  endtask

  task automatic test_backpressure();
    run_cmd(1'b1, US_SHL, 4'd1, 4'b1011);
    for (int i = 0; i < 5; i++) begin
      @(negedge Clock);
      cmd_valid = 1'b1; cmd_load = 1'b1; cmd_mode = US_SHR;
      cmd_count = 4'd0; cmd_data = 4'b1111;
      checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL bp_valid[%0d] got=%0b exp=1", i, rsp_valid); end
      checks++; if (rsp_data !== 4'b0110) begin failures++; $display("FAIL bp_data[%0d] got=%b exp=0110", i, rsp_data); end
      checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL bp_cmd_ready[%0d] got=%0b exp=0", i, cmd_ready); end
    end
    @(negedge Clock);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    rsp_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL bp_release_valid got=%0b exp=0", rsp_valid); end
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%0b exp=1", cmd_ready); end
    checks++; if (L !== 4'b1011) begin failures++; $display("FAIL bp_L_ignored got=%b exp=1011", L); end
  endtask

  task automatic test_reset_mid();
    @(negedge Clock);
    cmd_valid = 1'b1; cmd_load = 1'b0; cmd_mode = US_ROL;
    cmd_count = 4'd7; cmd_data = 4'd0;
    @(posedge Clock);
    @(negedge Clock);
    cmd_valid = 1'b0;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    checks++; if (S !== US_ROL || cmd_ready !== 1'b0) begin failures++; $display("FAIL mid_shift S=%0d ready=%0b exp %0d/0", S, cmd_ready, US_ROL); end
    Resetn = 1'b0;
    @(posedge Clock);
    @(negedge Clock);
    Resetn = 1'b1;
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL mid_reset_idle got=%0b exp=1", cmd_ready); end
    checks++; if (S !== US_HOLD) begin failures++; $display("FAIL mid_reset_S got=%0d exp=%0d", S, US_HOLD); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL mid_reset_valid got=%0b exp=0", rsp_valid); end
    run_cmd(1'b1, US_SHL, 4'd1, 4'b1011);
    checks++; if (edges !== 4 || rsp_data !== 4'b0110) begin failures++; $display("FAIL post_reset_cmd edges=%0d data=%b exp 4/0110", edges, rsp_data); end
    finish_rsp();
  endtask

`ifdef UNIVSHIFT_ABORT_EN
  task automatic test_abort();
    int wait_cnt;
    @(negedge Clock);
    cmd_valid = 1'b1; cmd_load = 1'b1; cmd_mode = US_ROL;
    cmd_count = 4'd7; cmd_data = 4'b0001;
    @(posedge Clock);
    @(negedge Clock);
    cmd_valid = 1'b0;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    cmd_abort = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    cmd_abort = 1'b0;
    checks++; if (S !== US_HOLD) begin failures++; $display("FAIL abort_S got=%0d exp=%0d", S, US_HOLD); end
    wait_cnt = 0;
    while (!rsp_valid && wait_cnt < 10) begin
      @(negedge Clock);
      wait_cnt++;
    end
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL abort_rsp_timeout got=%0b exp=1", rsp_valid); end
    checks++; if (rsp_data !== 4'b0100) begin failures++; $display("FAIL abort_data got=%b exp=0100", rsp_data); end
    checks++; if (rsp_err !== 1'b1) begin failures++; $display("FAIL abort_err got=%0b exp=1", rsp_err); end
    finish_rsp();
  endtask
`endif

  initial begin
    test_reset();
    test_load_shl();
    test_load_ror();
    test_noload_count0();
    test_illegal_mode();
    test_hold_mode();
    test_modes();
    test_backpressure();
    test_reset_mid();
`ifdef UNIVSHIFT_ABORT_EN
    test_abort();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
